// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo
//   Output stage for the 8-tap moving-average FIR. Discards the filter's
//   pipeline warm-up samples, then keeps one sample in every DECIM. Each kept
//   sample is saturated to OUT_W bits and written into a DEPTH-entry FIFO.
//   The consumer drains the FIFO over a valid/ready handshake.
//
// Ports
//   CLK        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   in_data carries a filter sample this cycle
//   in_data    unsigned filter output, IN_W bits
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data holds the FIFO head
//   out_data   oldest buffered sample, OUT_W bits
//   level      current FIFO occupancy, 0..DEPTH
//   ovf        sticky flag: a kept sample was lost to a full FIFO
//   ovf_clr    clears ovf (a simultaneous overflow event wins)
//
// Handshake: a word moves to the consumer on every rising edge where
//   out_valid && out_ready. out_valid never depends on out_ready. out_data
//   stays stable while out_valid is high and no transfer happens. out_ready
//   is ignored while the FIFO is empty.
//
// The saturation compare assumes IN_W >= OUT_W.

module fir_decim_fifo #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int DECIM = 4,
  parameter int PRIME = 8,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  // Both counters keep at least one bit so PRIME=0 and DECIM=1 still elaborate.
  localparam int PW = (PRIME > 0) ? $clog2(PRIME+1) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]    prime_cnt;
  logic [DW-1:0]    phase;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OUT_W-1:0] mem [DEPTH];

  logic             warm_done;
  logic             keep;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [OUT_W-1:0] sat_data;

  assign warm_done = (prime_cnt == PW'(PRIME));
  assign keep      = in_valid && warm_done && (phase == '0);
  assign sat_data  = (in_data > IN_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}}
                                                      : in_data[OUT_W-1:0];

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // When the FIFO is full, the slot freed by a same-cycle pop takes the new word.
  assign push      = keep && (!full || pop);
  assign drop      = keep && full && !pop;

  // Warm-up counter saturates at PRIME. The decimation phase only runs after warm-up.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      prime_cnt <= '0;
      phase     <= '0;
    end else if (in_valid) begin
      if (!warm_done) begin
        prime_cnt <= prime_cnt + PW'(1);
      end else if (phase == DW'(DECIM-1)) begin
        phase <= '0;
      end else begin
        phase <= phase + DW'(1);
      end
    end
  end

  // FIFO storage is cleared at reset so out_data reads 0 straight after reset.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= sat_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag. A set in the same cycle as a clear takes priority.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// tb_fir_decim_fifo
//   Directed bench for fir_decim_fifo. The instance dut uses the default
//   parameters. The instance dut1 uses DECIM=1 and PRIME=0 to check the
//   saturation boundaries. The driver pushes hand-computed expected words
//   into queues. Monitors pop those queues whenever a transfer happens.

module tb_fir_decim_fifo;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst;
  int   cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid, out_ready, ovf_clr;
  logic [18:0] in_data;
  logic        out_valid, ovf;
  logic [15:0] out_data;
  logic [3:0]  level;

  logic        in_valid1, out_ready1, ovf_clr1;
  logic [18:0] in_data1;
  logic        out_valid1, ovf1;
  logic [15:0] out_data1;
  logic [3:0]  level1;

  fir_decim_fifo dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  fir_decim_fifo #(.DECIM(1), .PRIME(0)) dut1 (
    .CLK(CLK), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .level(level1), .ovf(ovf1), .ovf_clr(ovf_clr1)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];   // -1 = no latency check for this word
  logic [15:0] exp1_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [18:0] d, input logic r);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic kept(input logic [18:0] d, input logic [15:0] e, input logic r,
                      input bit push_exp, input bit lat);
    step(1'b1, d, r);
    if (push_exp) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(lat ? cyc + 1 : -1);
    end
  endtask

  // One decimation period: a kept sample, then three skipped samples. The
  // skipped values saturate, so a wrongly kept one shows up as FFFF.
  task automatic group(input logic [18:0] d, input logic r, input bit push_exp);
    kept(d, d[15:0], r, push_exp, 1'b0);
    repeat (3) step(1'b1, 19'h7_FFFF, r);
  endtask

  task automatic warm(input logic r);
    repeat (8) step(1'b1, 19'h7_0000, r);
  endtask

  task automatic do_reset(input bit check);
    @(posedge CLK);
    #3;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_level",     level,     0);
      chk("rst_ovf",       ovf,       0);
    end
    exp_q.delete();
    exp_cyc_q.delete();
    exp1_q.delete();
    @(negedge CLK);
    rst = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() + exp1_q.size()) != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_timeout", exp_q.size() + exp1_q.size(), 0);
  endtask

  logic [18:0] t3_in  [5] = '{19'h1_0000, 19'h0_ABCD, 19'h7_FFFF, 19'h0_FFFF, 19'h0_0000};
  logic [15:0] t3_exp [5] = '{16'hFFFF,   16'hABCD,   16'hFFFF,   16'hFFFF,   16'h0000};

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1; ovf_clr1 = 1'b0;

    fork
      begin : mon
        logic [15:0] e;
        int          c;
        forever begin
          @(negedge CLK);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out: got %0h, expected no output (t=%0t)", out_data, $time);
            end else begin
              e = exp_q.pop_front();
              c = exp_cyc_q.pop_front();
              chk("out_data", out_data, e);
              if (c >= 0) chk("latency_cycle", cyc, c);
            end
          end
        end
      end
      begin : mon1
        forever begin
          @(negedge CLK);
          if (out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out1: got %0h, expected no output (t=%0t)", out_data1, $time);
            end else begin
              chk("sat_out_data", out_data1, exp1_q.pop_front());
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data",  out_data,  0);
    chk("init_level",     level,     0);
    chk("init_ovf",       ovf,       0);

    // Saturation boundaries on the DECIM=1, PRIME=0 instance.
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      in_valid1 = 1'b1;
      in_data1  = t3_in[i];
      exp1_q.push_back(t3_exp[i]);
    end
    @(posedge CLK);
    #1;
    in_valid1 = 1'b0;
    wait_drain();

    // Warm-up and decimation: inputs 0..19 give outputs 8, 12, 16, one cycle later each.
    for (int i = 0; i < 20; i++) begin
      if (i == 8 || i == 12 || i == 16) kept(19'(i), 16'(i), 1'b1, 1'b1, 1'b1);
      else step(1'b1, 19'(i), 1'b1);
    end
    step(1'b0, '0, 1'b1);
    wait_drain();

    // Overflow: 9 kept samples with the consumer stalled, so the 9th is lost.
    for (int k = 0; k < 9; k++) group(19'(100 + k), 1'b0, k < 8);
    step(1'b0, '0, 1'b0);
    chk("ovf_level", level, 8);
    chk("ovf_set",   ovf,   1);
    step(1'b0, '0, 1'b1);
    wait_drain();
    chk("ovf_sticky", ovf, 1);
    @(posedge CLK); #1; ovf_clr = 1'b1;
    @(posedge CLK); #1; ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    chk("drained_level", level, 0);

    // Full FIFO: a push and a pop in the same cycle.
    for (int k = 0; k < 8; k++) group(19'(200 + k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("full_level", level, 8);
    kept(19'd300, 16'd300, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("pushpop_level", level, 8);
    chk("pushpop_ovf",   ovf,   0);
    step(1'b0, '0, 1'b1);
    wait_drain();

    // Async reset mid-run with the FIFO full and ovf set.
    do_reset(1'b0);
    warm(1'b0);
    for (int k = 0; k < 9; k++) group(19'(400 + k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("pre_rst_ovf", ovf, 1);
    do_reset(1'b1);

    // Reset at level 5 restarts warm-up.
    warm(1'b0);
    for (int k = 0; k < 5; k++) group(19'(500 + k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("lvl5_level", level, 5);
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 19'(19'h42 + i), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rewarm_level", level, 0);
    kept(19'h77, 16'h77, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
